// File: rtl/dma_pkg.sv
// Constants and state type shared by the external device buffer and the DMA engine.
package dma_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int CHUNK_WORDS = 4;
  localparam int NUM_CHUNKS  = 3;
  localparam int NUM_WORDS   = CHUNK_WORDS * NUM_CHUNKS;
  localparam int CHUNK_BITS  = CHUNK_WORDS * WORD_SIZE;
  localparam int OFFSET_W    = 2;
  localparam int WPTR_W      = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2,
    XFER = 2'd3
  } dev_state_t;

  // A zero trigger delay still needs a one-bit timer.
  function automatic int timer_width(input int delay);
    return (delay > 0) ? $clog2(delay + 1) : 1;
  endfunction

endpackage

// File: rtl/dev_chunk_buf.sv
// Word-wide write, chunk-wide read register file; chunk indices past the end read as zero.
module dev_chunk_buf
  import dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WPTR_W-1:0]     wr_addr,
  input  logic [WORD_SIZE-1:0]  wr_data,
  input  logic [OFFSET_W-1:0]   rd_chunk,
  output logic [CHUNK_BITS-1:0] rd_data
);

  logic [WORD_SIZE-1:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < NUM_WORDS)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      if (int'(rd_chunk) == c) begin
        for (int w = 0; w < CHUNK_WORDS; w++) begin
          rd_data[w*WORD_SIZE +: WORD_SIZE] = mem_q[c*CHUNK_WORDS + w];
        end
      end
    end
  end

endmodule

// File: rtl/ext_device_buffer.sv
// External device buffer: collects a block of words, interrupts the CPU after a delay,
// then serves the block to the DMA engine chunk by chunk until the DMA signals done.
//
//   state | meaning
//   FILL  | accepting producer words into the buffer
//   WAIT  | buffer full, trigger-delay timer counting down
//   REQ   | irq raised, waiting for the CPU acknowledge
//   XFER  | DMA reading chunks on edata, waiting for dma_done
module ext_device_buffer
  import dma_pkg::*;
#(
  parameter int TRIGGER_DELAY = 8
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  load_valid,
  input  logic [WORD_SIZE-1:0]  load_data,
  output logic                  load_ready,
  output logic                  irq,
  input  logic                  irq_ack,
  input  logic [OFFSET_W-1:0]   offset,
  input  logic                  rd_en,
  output logic [CHUNK_BITS-1:0] edata,
  input  logic                  dma_done,
  output logic                  busy,
  output logic                  error
);

  localparam int                    TIMER_W    = timer_width(TRIGGER_DELAY);
  localparam logic [TIMER_W-1:0]    TIMER_INIT = TIMER_W'(TRIGGER_DELAY);
  localparam logic [WPTR_W-1:0]     WPTR_LAST  = WPTR_W'(NUM_WORDS - 1);
  localparam logic [NUM_CHUNKS-1:0] MASK_FULL  = '1;

  dev_state_t            state_q;
  logic [WPTR_W-1:0]     wptr_q;
  logic [TIMER_W-1:0]    timer_q;
  logic [NUM_CHUNKS-1:0] mask_q;
  logic [NUM_CHUNKS-1:0] mask_d;
  logic                  irq_q;
  logic                  load_ready_q;
  logic                  busy_q;
  logic                  error_q;
  logic                  ofs_ok;
  logic                  wr_en;
  logic [CHUNK_BITS-1:0] chunk_data;

  assign ofs_ok = int'(offset) < NUM_CHUNKS;
  assign wr_en  = (state_q == FILL) && load_valid;

  always_comb begin
    mask_d = mask_q;
    if (rd_en && ofs_ok) mask_d[offset] = 1'b1;
  end

  dev_chunk_buf u_buf (
    .clk      (CLK),
    .rst_n    (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wptr_q),
    .wr_data  (load_data),
    .rd_chunk (offset),
    .rd_data  (chunk_data)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      wptr_q       <= '0;
      timer_q      <= '0;
      mask_q       <= '0;
      irq_q        <= 1'b0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (dma_done) error_q <= 1'b1;
          if (load_valid) begin
            wptr_q <= wptr_q + WPTR_W'(1);
            if (wptr_q == WPTR_LAST) begin
              state_q      <= WAIT;
              timer_q      <= TIMER_INIT;
              load_ready_q <= 1'b0;
              busy_q       <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (dma_done) error_q <= 1'b1;
          if (timer_q == '0) state_q <= REQ;
          else               timer_q <= timer_q - TIMER_W'(1);
        end
        REQ: begin
          if (dma_done) error_q <= 1'b1;
          // The acknowledge is only honoured once irq has been visible for a cycle.
          if (!irq_q) begin
            irq_q <= 1'b1;
          end else if (irq_ack) begin
            irq_q   <= 1'b0;
            state_q <= XFER;
          end
        end
        XFER: begin
          mask_q <= mask_d;
          if (rd_en && !ofs_ok) error_q <= 1'b1;
          if (dma_done) begin
            if (mask_d != MASK_FULL) error_q <= 1'b1;
            state_q      <= FILL;
            wptr_q       <= '0;
            mask_q       <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign edata      = (state_q == XFER) ? chunk_data : '0;
  assign irq        = irq_q;
  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule
